seg_shift_rx: RTL

Serial-to-parallel receiver for the display/LED shift-out protocol that the Display and GPIO blocks drive: a serial clock, serial data, an active-low clear and a latch enable. It oversamples the four serial lines on the system clock and reassembles each frame into a parallel word. It sits on the far end of those lines, as a daughter-board capture block and as the checker the display bench uses to compare shifted words against Disp_num/LED_out. It also flags malformed frames (wrong bit count).

---
 rtl/seg_rx_pkg.sv | 18 +
 rtl/seg_shift_rx_sync_edge.sv | 28 ++
 rtl/seg_shift_rx.sv | 119 +++++++++++
 3 files changed

// File: rtl/seg_rx_pkg.sv
// Shared types and constants for the serial shift-out receiver.
package seg_rx_pkg;

   localparam int SEG_WIDTH = 64;
   localparam int LED_WIDTH = 16;

   typedef logic [1:0] rx_state_t;

   localparam rx_state_t IDLE = 2'd0;
   localparam rx_state_t RECV = 2'd1;
   localparam rx_state_t FULL = 2'd2;
   localparam rx_state_t OVER = 2'd3;

   function automatic int CNT_W(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/seg_shift_rx_sync_edge.sv
// One serial line: synchronizer chain, history flop, rising-edge strobe.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic lvl_o,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign lvl_o  = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/seg_shift_rx.sv
// Oversampling serial-to-parallel receiver for the display/LED chain.
module seg_shift_rx
   import seg_rx_pkg::*;
#(
   parameter int WIDTH       = SEG_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    RSTN,
   input  logic                    ser_clk,
   input  logic                    ser_dat,
   input  logic                    ser_clrn,
   input  logic                    ser_en,
   input  logic                    err_clr,
   output logic [WIDTH-1:0]        data_out,
   output logic                    data_valid,
   output logic                    frame_err,
   output logic [CNT_W(WIDTH)-1:0] bit_cnt,
   output logic                    busy
);

   localparam int CW = CNT_W(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

   logic [3:0] in_w, lvl_w, rise_w;
   logic       clk_rise, en_rise, s_dat, s_clrn;
   logic       unused_w;

   assign in_w = {ser_clk, ser_dat, ser_clrn, ser_en};

   for (genvar g = 0; g < 4; g++) begin : g_sync
      sync_edge #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .rstn   (RSTN),
         .d_i    (in_w[g]),
         .lvl_o  (lvl_w[g]),
         .rise_o (rise_w[g])
      );
   end

   assign clk_rise = rise_w[3];
   assign s_dat    = lvl_w[2];
   assign s_clrn   = lvl_w[1];
   assign en_rise  = rise_w[0];
   assign unused_w = ^{lvl_w[3], lvl_w[0], rise_w[2:1]};

   logic [WIDTH-1:0] shreg_q, shreg_d, sh_w;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_sh;
   rx_state_t        state_q, state_d, st_sh;
   logic             err_q, err_d, dv_q;
   logic             good, bad;

   // Shift first, so the latch decision sees the post-shift frame.
   always_comb begin
      sh_w   = shreg_q;
      cnt_sh = cnt_q;
      st_sh  = state_q;
      if (clk_rise) begin
         sh_w = {shreg_q[WIDTH-2:0], s_dat};
         if (cnt_q != CNT_MAX) cnt_sh = cnt_q + 1'b1;
         case (state_q)
            IDLE:    st_sh = (WIDTH == 1) ? FULL : RECV;
            RECV:    st_sh = (cnt_q == CNT_LAST) ? FULL : RECV;
            FULL:    st_sh = OVER;
            OVER:    st_sh = OVER;
            default: st_sh = IDLE;
         endcase
      end
   end

   always_comb begin
      good    = 1'b0;
      bad     = 1'b0;
      shreg_d = sh_w;
      cnt_d   = cnt_sh;
      state_d = st_sh;
      if (!s_clrn) begin
         shreg_d = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end else if (en_rise) begin
         cnt_d   = '0;
         state_d = IDLE;
         good    = (st_sh == FULL);
         bad     = (st_sh != FULL);
      end
      err_d  = bad ? 1'b1 : (err_clr ? 1'b0 : err_q);
      dout_d = good ? sh_w : dout_q;
   end

   always_ff @(posedge clk) begin
      if (!RSTN) begin
         shreg_q <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         state_q <= IDLE;
         err_q   <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         err_q   <= err_d;
         dv_q    <= good;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign frame_err  = err_q;
   assign bit_cnt    = cnt_q;
   assign busy       = (cnt_q != '0);

endmodule
